// File: rtl/bcd_xs3_pkg.sv
// Shared types and constants for the two-requester BCD to excess-3 scheduler.
// Range checking of incoming digits is enabled by defining BCD_CHECK_EN.
package bcd_xs3_pkg;

    localparam int NUM_REQ    = 2;
    localparam int DIGIT_W    = 4;
    localparam int XS3_OFFSET = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sched_state_t;

    // Converter state: bit position plus pending carry. Position 0 never carries in.
    typedef enum logic [2:0] {
        CV_B0    = 3'd0,
        CV_B1_C0 = 3'd1,
        CV_B1_C1 = 3'd2,
        CV_B2_C0 = 3'd3,
        CV_B2_C1 = 3'd4,
        CV_B3_C0 = 3'd5,
        CV_B3_C1 = 3'd6
    } conv_state_t;

    function automatic logic digit_out_of_range(input logic [DIGIT_W-1:0] d);
        return (d > 4'd9);
    endfunction

endpackage

// File: rtl/bcd_xs3_sched_if.sv
// Request/response bundle between two digit requesters, the scheduler and its result consumer.
interface bcd_xs3_sched_if;
    logic [1:0] req_valid;
    logic [3:0] req_digit0;
    logic [3:0] req_digit1;
    logic [1:0] req_ready;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_digit;
    logic       rsp_id;
    logic       rsp_err;

    modport master (
        output req_valid, req_digit0, req_digit1, rsp_ready,
        input  req_ready, rsp_valid, rsp_digit, rsp_id, rsp_err
    );

    modport slave (
        input  req_valid, req_digit0, req_digit1, rsp_ready,
        output req_ready, rsp_valid, rsp_digit, rsp_id, rsp_err
    );
endinterface

// File: rtl/bcd_xs3_serial.sv
// Serial LSB-first Mealy machine that adds 3 to a 4-bit digit; the final carry is dropped.
module bcd_xs3_serial
    import bcd_xs3_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic x,
    output logic y
);

    conv_state_t state_r;
    conv_state_t state_nxt_s;

    // State register; clr restarts at bit 0 for a new digit.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            state_r <= CV_B0;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Sum bit and carry for constant addend 0011, one bit per cycle.
    always_comb begin
        y           = 1'b0;
        state_nxt_s = CV_B0;
        case (state_r)
            CV_B0: begin
                y           = ~x;
                state_nxt_s = x ? CV_B1_C1 : CV_B1_C0;
            end
            CV_B1_C0: begin
                y           = ~x;
                state_nxt_s = x ? CV_B2_C1 : CV_B2_C0;
            end
            CV_B1_C1: begin
                y           = x;
                state_nxt_s = CV_B2_C1;
            end
            CV_B2_C0: begin
                y           = x;
                state_nxt_s = CV_B3_C0;
            end
            CV_B2_C1: begin
                y           = ~x;
                state_nxt_s = x ? CV_B3_C1 : CV_B3_C0;
            end
            CV_B3_C0: begin
                y           = x;
                state_nxt_s = CV_B0;
            end
            CV_B3_C1: begin
                y           = ~x;
                state_nxt_s = CV_B0;
            end
            default: begin
                y           = 1'b0;
                state_nxt_s = CV_B0;
            end
        endcase
    end

endmodule

// File: rtl/bcd_xs3_sched.sv
// Round-robin scheduler sharing one serial excess-3 converter between two requesters.
// Optional BCD_CHECK_EN: digits above 9 are answered in one cycle with rsp_err set.
module bcd_xs3_sched
    import bcd_xs3_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    bcd_xs3_sched_if.slave  bus
);

    sched_state_t state_r;
    sched_state_t state_nxt_s;
    logic [1:0]   cnt_r;
    logic [3:0]   digit_r;
    logic         id_r;
    logic         last_r;
    logic [2:0]   res_r;
    logic         rsp_valid_r;
    logic [3:0]   rsp_digit_r;
    logic         rsp_id_r;
    logic         grant_s;
    logic [1:0]   ready_s;
    logic         accept_s;
    logic [3:0]   acc_digit_s;
    logic         conv_x_s;
    logic         conv_y_s;
`ifdef BCD_CHECK_EN
    logic         bad_s;
    logic         rsp_err_r;
`endif

    bcd_xs3_serial u_conv (
        .clk   (clk),
        .reset (reset),
        .clr   (accept_s),
        .x     (conv_x_s),
        .y     (conv_y_s)
    );

    // Arbiter: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        grant_s = 1'b0;
        case (bus.req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_r;
            default: grant_s = 1'b0;
        endcase
        if (state_r == IDLE) begin
            ready_s = {grant_s & bus.req_valid[1], ~grant_s & bus.req_valid[0]};
        end else begin
            ready_s = 2'b00;
        end
        accept_s    = |ready_s;
        acc_digit_s = grant_s ? bus.req_digit1 : bus.req_digit0;
        conv_x_s    = (state_r == SHIFT) ? digit_r[cnt_r] : 1'b0;
`ifdef BCD_CHECK_EN
        bad_s       = digit_out_of_range(acc_digit_s);
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef BCD_CHECK_EN
                    state_nxt_s = bad_s ? DONE : SHIFT;
`else
                    state_nxt_s = SHIFT;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == 2'd3) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (rsp_valid_r && bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Datapath: latch request, shift converter output in LSB first, publish result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= 2'd0;
            digit_r     <= 4'd0;
            id_r        <= 1'b0;
            last_r      <= 1'b1;
            res_r       <= 3'd0;
            rsp_valid_r <= 1'b0;
            rsp_digit_r <= 4'd0;
            rsp_id_r    <= 1'b0;
`ifdef BCD_CHECK_EN
            rsp_err_r   <= 1'b0;
`endif
        end else if (accept_s) begin
            cnt_r   <= 2'd0;
            digit_r <= acc_digit_s;
            id_r    <= grant_s;
            last_r  <= grant_s;
`ifdef BCD_CHECK_EN
            if (bad_s) begin
                rsp_valid_r <= 1'b1;
                rsp_digit_r <= 4'd0;
                rsp_id_r    <= grant_s;
                rsp_err_r   <= 1'b1;
            end
`endif
        end else if (state_r == SHIFT) begin
            cnt_r <= cnt_r + 2'd1;
            res_r <= {conv_y_s, res_r[2:1]};
            if (cnt_r == 2'd3) begin
                rsp_valid_r <= 1'b1;
                rsp_digit_r <= {conv_y_s, res_r};
                rsp_id_r    <= id_r;
`ifdef BCD_CHECK_EN
                rsp_err_r   <= 1'b0;
`endif
            end
        end else if ((state_r == DONE) && rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_digit = rsp_digit_r;
    assign bus.rsp_id    = rsp_id_r;
`ifdef BCD_CHECK_EN
    assign bus.rsp_err   = rsp_err_r;
`else
    assign bus.rsp_err   = 1'b0;
`endif

endmodule

// File: doc/bcd_xs3_sched.md
BCD_XS3_SCHED -- requirements
Module: bcd_xs3_sched

Interface
REQ-001 The interface SHALL use reset reset, synchronous, active-high, and clock clk.
REQ-002 Ports SHALL be, in order:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid  input  2  per-requester digit valid, bit i = requester i
- req_digit0  input  4  requester 0 BCD digit
- req_digit1  input  4  requester 1 BCD digit
- req_ready  output  2  per-requester accept, one-hot or zero
- rsp_valid  output  1  result valid
- rsp_ready  input  1  result consumer ready
- rsp_digit  output  4  excess-3 result
- rsp_id  output  1  requester index of the result
- rsp_err  output  1  digit-range error; present only with BCD_CHECK_EN, otherwise tied 0

Function
REQ-003 The block SHALL share one serial LSB-first excess-3 Mealy converter between two requesters: it accepts one parallel digit, serialises it through the converter, and returns the parallel result.
REQ-004 The FSM SHALL have three states:
- IDLE to SHIFT on accept.
- SHIFT to DONE after 4 bit cycles.
- DONE to IDLE on rsp_valid & rsp_ready.
REQ-005 req_ready SHALL be asserted only in IDLE, only for the granted requester, and only while that requester's req_valid is high; accept = req_valid[i] & req_ready[i].
REQ-006 Arbitration SHALL be round-robin: if one requester is valid, grant it; if both are valid, grant the requester not granted last.
REQ-007 On the accept cycle (cycle 0), the digit and the requester index SHALL be registered, and the converter SHALL be cleared to its initial state.
REQ-008 In SHIFT cycles 1..4, bit k=cycle-1 of the latched digit SHALL drive the converter x input, and converter y SHALL be captured into result bit k at the end of that cycle.
REQ-009 rsp_valid SHALL rise in cycle 5, a fixed latency of 5 cycles from accept.
REQ-010 rsp_digit, rsp_id and rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-011 Result arithmetic SHALL be rsp_digit = (digit + 3) mod 16, and the final carry SHALL be discarded.
REQ-012 There SHALL be no accept in the cycle a response completes; IDLE is re-entered first, so minimum spacing is 6 cycles per digit.
REQ-013 req_valid changes during SHIFT or DONE SHALL have no effect on the transaction in flight.

Reset
REQ-014 Reset SHALL force:
- state=IDLE, rsp_valid=0, req_ready=0, rsp_digit=0, rsp_id=0, rsp_err=0.
- Converter to its initial state.
- Round-robin pointer so that requester 0 wins the first contention.
REQ-015 Reset asserted mid-SHIFT or mid-DONE SHALL drop the in-flight digit with no response produced.

Configuration
REQ-016 With macro BCD_CHECK_EN defined, an accepted digit greater than 9 SHALL skip SHIFT and go to DONE in cycle 1 with rsp_err=1 and rsp_digit=0; rsp_id SHALL still be valid.
REQ-017 Without BCD_CHECK_EN, all 16 digit values SHALL be converted per REQ-011, the rsp_err port SHALL be driven 0, and no range logic SHALL be present.

Structure
REQ-018 A shared package bcd_xs3_pkg SHALL hold:
- NUM_REQ=2, DIGIT_W=4, XS3_OFFSET=3.
- The FSM state enum {IDLE, SHIFT, DONE}.
- The converter state enum.
REQ-019 The converter SHALL be a sub-module, bcd_xs3_serial, with ports clk, reset, clr, x and y, where y is combinational from state and x (Mealy).
REQ-020 The scheduler SHALL contain the FSM, the 2-bit bit counter, the shift/result registers and the arbiter only.

Verification
REQ-021 Reset, then req0 digit 5 -> req_ready[0] in cycle 0; rsp_valid in cycle 5 with rsp_digit=8, rsp_id=0.
REQ-022 Both requesters valid after reset (req0=2, req1=9) -> req0 served first (result 5); then req1 served (result 12, id 1); ready never high in SHIFT/DONE.
REQ-023 rsp_ready held low 3 cycles after rsp_valid -> outputs stable; return to IDLE the cycle after rsp_ready=1.
REQ-024 Digit 12 from req1: with BCD_CHECK_EN -> rsp_valid in cycle 1 with rsp_err=1, rsp_digit=0; without -> rsp_digit=15 in cycle 5.
REQ-025 Reset pulsed in SHIFT cycle 2 -> no rsp_valid; the next digit (0) yields 3 correctly.
REQ-026 Sweep of digits 0..9 on both requesters -> every result equals digit+3; grants alternate under continuous contention.
